// File: rtl/la_capture_pkg.sv
// Shared state encoding and default sizing for the logic-analyser capture block.
package la_pkg;
    localparam int LA_WIDTH    = 8;
    localparam int LA_DEPTH    = 16;
    localparam int LA_PRE_TRIG = 4;

    typedef enum logic [2:0] {
        LA_IDLE,
        LA_PRE,
        LA_WAIT_TRIG,
        LA_POST,
        LA_READOUT
    } la_state_t;
endpackage

// File: rtl/la_capture_if.sv
// Readout handshake: the capture block is the master, the consumer is the slave.
interface la_capture_if import la_pkg::*; #(
    parameter int WIDTH = LA_WIDTH
);
    logic             rd_valid;
    logic             rd_ready;
    logic [WIDTH-1:0] rd_data;
    logic             rd_last;

    modport master (output rd_valid, output rd_data, output rd_last, input rd_ready);
    modport slave  (input rd_valid, input rd_data, input rd_last, output rd_ready);
endinterface

// File: rtl/la_capture_mem.sv
// Capture buffer: register array, one synchronous write port, one combinational read port.
module la_capture_mem import la_pkg::*; #(
    parameter int WIDTH = LA_WIDTH,
    parameter int DEPTH = LA_DEPTH
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    // No reset: contents are always overwritten before they are read out.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/la_capture.sv
// Logic-analyser capture: ring-buffer pre-trigger history, pattern trigger,
// post-trigger fill, then chronological readout over a valid/ready handshake.
//
// state        | meaning
// LA_IDLE      | waiting for arm
// LA_PRE       | filling the first PRE_TRIG history samples
// LA_WAIT_TRIG | writing into the ring until the masked pattern matches
// LA_POST      | writing the post-trigger samples
// LA_READOUT   | streaming DEPTH words, oldest first
module la_capture import la_pkg::*; #(
    parameter int WIDTH    = LA_WIDTH,
    parameter int DEPTH    = LA_DEPTH,
    parameter int PRE_TRIG = LA_PRE_TRIG
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] la_in,
    input  logic             arm,
    input  logic             abort,
    input  logic [WIDTH-1:0] trig_mask,
    input  logic [WIDTH-1:0] trig_value,
    la_capture_if.master     rd,
    output logic             busy,
    output logic             done
);
    localparam int PW     = $clog2(DEPTH);
    localparam int CW     = PW + 1;
    localparam int POST_N = DEPTH - PRE_TRIG - 1;
    localparam logic [PW-1:0] PRE_OFS = PW'(PRE_TRIG);

    la_state_t        r_state;
    logic [WIDTH-1:0] r_s;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_trig_ptr;
    logic [CW-1:0]    r_cnt;
    logic             r_rd_valid;
    logic             r_rd_last;
    logic             r_done;
    logic             w_we;
    logic             w_hit;
    logic [WIDTH-1:0] w_rd_data;

    assign w_we  = !abort && (r_state inside {LA_PRE, LA_WAIT_TRIG, LA_POST});
    assign w_hit = ((r_s ^ trig_value) & trig_mask) == '0;

    la_capture_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (r_s),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= LA_IDLE;
            r_s        <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_trig_ptr <= '0;
            r_cnt      <= '0;
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_s    <= la_in;
            r_done <= 1'b0;
            if (w_we) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (abort) begin
                r_state    <= LA_IDLE;
                r_rd_valid <= 1'b0;
                r_rd_last  <= 1'b0;
            end else begin
                case (r_state)
                    LA_IDLE: begin
                        if (arm) begin
                            r_wr_ptr <= '0;
                            r_cnt    <= '0;
                            r_state  <= (PRE_TRIG == 0) ? LA_WAIT_TRIG : LA_PRE;
                        end
                    end
                    LA_PRE: begin
                        r_cnt <= r_cnt + 1'b1;
                        if (int'(r_cnt) == PRE_TRIG - 1) begin
                            r_cnt   <= '0;
                            r_state <= LA_WAIT_TRIG;
                        end
                    end
                    LA_WAIT_TRIG: begin
                        if (w_hit) begin
                            r_trig_ptr <= r_wr_ptr;
                            r_cnt      <= '0;
                            if (POST_N == 0) begin
                                r_rd_ptr   <= r_wr_ptr - PRE_OFS;
                                r_rd_valid <= 1'b1;
                                r_state    <= LA_READOUT;
                            end else begin
                                r_state <= LA_POST;
                            end
                        end
                    end
                    LA_POST: begin
                        r_cnt <= r_cnt + 1'b1;
                        if (int'(r_cnt) == POST_N - 1) begin
                            r_cnt      <= '0;
                            r_rd_ptr   <= r_trig_ptr - PRE_OFS;
                            r_rd_valid <= 1'b1;
                            r_state    <= LA_READOUT;
                        end
                    end
                    LA_READOUT: begin
                        if (rd.rd_ready) begin
                            r_rd_ptr  <= r_rd_ptr + 1'b1;
                            r_cnt     <= r_cnt + 1'b1;
                            r_rd_last <= (int'(r_cnt) == DEPTH - 2);
                            if (r_rd_last) begin
                                r_rd_valid <= 1'b0;
                                r_rd_last  <= 1'b0;
                                r_done     <= 1'b1;
                                r_state    <= LA_IDLE;
                            end
                        end
                    end
                    default: r_state <= LA_IDLE;
                endcase
            end
        end
    end

    assign rd.rd_valid = r_rd_valid;
    assign rd.rd_last  = r_rd_last;
    assign rd.rd_data  = w_rd_data;
    assign busy        = (r_state != LA_IDLE);
    assign done        = r_done;
endmodule

// File: doc/la_capture.md
LA_CAPTURE -- requirements
Module: la_capture

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of LA probe lines sampled.
REQ-002 SHALL have parameter DEPTH, default 16, capture buffer words; power of two, at least 4.
REQ-003 SHALL have parameter PRE_TRIG, default 4, number of samples kept before the trigger; less than DEPTH.
REQ-004 SHALL have one clock and a synchronous, active-high reset; the port list is as follows.
REQ-005 clk  input  1  sole clock, all state on posedge.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 la_in  input  WIDTH  LA probe lines from the FF stages (out OR LA_Test).
REQ-008 arm  input  1  start-capture request, honoured only in IDLE.
REQ-009 abort  input  1  cancels any capture or readout.
REQ-010 trig_mask  input  WIDTH  bits compared for the trigger.
REQ-011 trig_value  input  WIDTH  trigger pattern.
REQ-012 rd_valid  output  1  readout word available.
REQ-013 rd_ready  input  1  consumer accepts the word.
REQ-014 rd_data  output  WIDTH  readout word.
REQ-015 rd_last  output  1  marks the final readout word.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 done  output  1  one-cycle pulse after the last word transfers.

Function
REQ-018 SHALL register la_in once into a sample register s; only s is stored or compared, giving 1 cycle of input latency.
REQ-019 SHALL implement the states IDLE, PRE, WAIT_TRIG, POST and READOUT.
REQ-020 IDLE to PRE: when arm=1 and abort=0; wr_ptr and the counters clear to 0.
REQ-021 PRE: writes s to mem[wr_ptr] every cycle and increments wr_ptr; moves to WAIT_TRIG after PRE_TRIG writes (immediately if PRE_TRIG=0).
REQ-022 WAIT_TRIG: writes s every cycle with wr_ptr wrapping modulo DEPTH; trigger when (s & trig_mask) == (trig_value & trig_mask); the trigger-cycle sample is written and trig_ptr is set to its address.
REQ-023 A trig_mask of all zeros SHALL trigger on the first WAIT_TRIG cycle.
REQ-024 POST: writes exactly DEPTH-PRE_TRIG-1 further samples, then moves to READOUT.
REQ-025 READOUT: rd_ptr starts at (trig_ptr - PRE_TRIG) mod DEPTH; rd_valid=1 and rd_data=mem[rd_ptr].
REQ-026 READOUT: rd_ptr advances only when rd_valid and rd_ready are both 1; rd_data and rd_valid SHALL hold while rd_ready=0.
REQ-027 rd_last SHALL be high on the DEPTH-th word; its transfer returns the block to IDLE, with done=1 for the following cycle only.
REQ-028 Readout order SHALL be chronological: the oldest pre-trigger sample first and the trigger sample at index PRE_TRIG.
REQ-029 abort=1 in any state SHALL force IDLE on the next cycle, with no done pulse; rd_valid drops on that edge.
REQ-030 If abort and arm are asserted together in IDLE, abort SHALL win and the block stays in IDLE.
REQ-031 arm outside IDLE SHALL be ignored.
REQ-032 Trigger inputs are sampled every cycle; changes mid-capture take effect on the next compare.

Reset
REQ-033 reset SHALL force state=IDLE, wr_ptr=rd_ptr=trig_ptr=0, counters=0, s=0, rd_valid=0, rd_last=0, busy=0 and done=0 on the next edge.
REQ-034 Buffer memory SHALL NOT be reset.
REQ-035 reset SHALL take priority over abort and arm.
REQ-036 reset mid-operation SHALL behave as a clean return to IDLE, and a subsequent arm SHALL work normally.

Structure
REQ-037 SHALL use package la_pkg holding the state enum la_state_t and default constants LA_WIDTH=8, LA_DEPTH=16, LA_PRE_TRIG=4.
REQ-038 SHALL instantiate one sub-module la_capture_mem: a DEPTH x WIDTH register array with one synchronous write port and one combinational read port.
REQ-039 Pointers SHALL be $clog2(DEPTH) bits wide with natural wrap; the readout counter SHALL be $clog2(DEPTH)+1 bits wide.

Verification
REQ-040 Defaults; la_in counts up by 1 from 0x00, arm while la_in=0x00, trig_mask=0xFF, trig_value=0x20, rd_ready=1 -> 16 words 0x1C..0x2B, rd_last on 0x2B, one done pulse.
REQ-041 trig_mask=0x00, la_in counting -> trigger on the first WAIT_TRIG sample; word 4 of the readout equals that sample.
REQ-042 Same as REQ-040 with rd_ready toggled 1010... -> identical sequence, and rd_data stable in every stalled cycle.
REQ-043 abort asserted in WAIT_TRIG -> busy=0 next cycle, no rd_valid, no done; a re-arm then succeeds.
REQ-044 reset asserted after 5 readout words -> rd_valid=0 and busy=0 next cycle; a re-run of REQ-040 passes.
REQ-045 arm pulsed during POST and during READOUT -> no effect; exactly 16 words and one done.
